// File: rtl/interrupt_ack_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ack_sequencer_if
// Description : Request, INTA/EOI handshake and vector bus bundle between the
//               priority resolver / CPU side and the acknowledge sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_ack_sequencer_if;
    logic [7:0] req_onehot;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_oe;

    // Environment side: drives requests, INTA and EOI; observes the responses
    modport master (
        output req_onehot, vector_base, inta_n, eoi_valid, eoi_specific, eoi_level,
        input  int_out, isr, irr_clear, data_out, data_oe
    );

    // Sequencer side
    modport slave (
        input  req_onehot, vector_base, inta_n, eoi_valid, eoi_specific, eoi_level,
        output int_out, isr, irr_clear, data_out, data_oe
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ack_sequencer
// Description : CPU-side responder of the PIC. Raises INT for an eligible
//               one-hot request, answers the two-pulse 8086 INTA handshake,
//               drives the vector byte and maintains the In-Service Register.
//               Optional feature macro: AUTO_EOI_EN (clears the serviced ISR
//               bit at the end of the second INTA pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_ack_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    interrupt_ack_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_ACK1 = 2'd2,
        S_ACK2 = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_inta_q;
    logic       r_int_out;
    logic [7:0] r_isr;
    logic [7:0] r_irr_clear;
    logic [7:0] r_data_out;
    logic       r_data_oe;
    logic [2:0] r_lvl;

    logic       w_int_out_nxt;
    logic [7:0] w_isr_nxt;
    logic [7:0] w_irr_clear_nxt;
    logic [7:0] w_data_out_nxt;
    logic       w_data_oe_nxt;
    logic [2:0] w_lvl_nxt;

`ifdef AUTO_EOI_EN
    // Distinguishes a genuine level 7 from the spurious code at auto-EOI time
    logic       r_lvl_real;
    logic       w_lvl_real_nxt;
`endif

    logic       w_fall;
    logic       w_rise;
    logic       w_req_present;
    logic [2:0] w_req_lvl;
    logic [7:0] w_span;
    logic       w_eligible;
    logic [7:0] w_eoi_mask;
    logic [7:0] w_set_mask;
    logic [7:0] w_clr_mask;

    assign w_fall        = r_inta_q & ~bus.inta_n;
    assign w_rise        = ~r_inta_q & bus.inta_n;
    assign w_req_present = |bus.req_onehot;

    // Encode the request level and build a mask of levels 0..L (equal or higher priority)
    always_comb begin
        logic acc;
        w_req_lvl = 3'd0;
        w_span    = 8'd0;
        acc       = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            acc       = acc | bus.req_onehot[i];
            w_span[i] = acc;
            if (bus.req_onehot[i]) begin
                w_req_lvl = 3'(i);
            end
        end
    end

    // A request is blocked while it or any higher-priority level is in service
    assign w_eligible = w_req_present & ~(|(r_isr & w_span));

    // EOI command decode: specific level, or lowest-index in-service bit
    always_comb begin
        w_eoi_mask = 8'd0;
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                w_eoi_mask = 8'd1 << bus.eoi_level;
            end else begin
                w_eoi_mask = r_isr & (~r_isr + 8'd1);
            end
        end
    end

    // Handshake sequencing: next state and next register values
    always_comb begin
        w_state_nxt     = r_state;
        w_int_out_nxt   = r_int_out;
        w_data_out_nxt  = r_data_out;
        w_data_oe_nxt   = r_data_oe;
        w_lvl_nxt       = r_lvl;
        w_irr_clear_nxt = 8'd0;
        w_set_mask      = 8'd0;
        w_clr_mask      = w_eoi_mask;
`ifdef AUTO_EOI_EN
        w_lvl_real_nxt  = r_lvl_real;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_eligible) begin
                    w_int_out_nxt = 1'b1;
                    w_state_nxt   = S_PEND;
                end
            end
            S_PEND: begin
                if (w_fall) begin
                    w_int_out_nxt = 1'b0;
                    w_state_nxt   = S_ACK1;
                    if (w_req_present) begin
                        w_lvl_nxt       = w_req_lvl;
                        w_set_mask      = 8'd1 << w_req_lvl;
                        w_irr_clear_nxt = 8'd1 << w_req_lvl;
                    end else begin
                        w_lvl_nxt       = SPURIOUS_LEVEL;
                    end
`ifdef AUTO_EOI_EN
                    w_lvl_real_nxt = w_req_present;
`endif
                end
            end
            S_ACK1: begin
                if (w_fall) begin
                    w_data_out_nxt = {bus.vector_base, r_lvl};
                    w_data_oe_nxt  = 1'b1;
                    w_state_nxt    = S_ACK2;
                end
            end
            S_ACK2: begin
                if (w_rise) begin
                    w_data_oe_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
`ifdef AUTO_EOI_EN
                    if (r_lvl_real) begin
                        w_clr_mask = w_clr_mask | (8'd1 << r_lvl);
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A set on the same bit as a clear takes precedence
        w_isr_nxt = (r_isr & ~w_clr_mask) | w_set_mask;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output, ISR and INTA history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inta_q    <= 1'b1;
            r_int_out   <= 1'b0;
            r_isr       <= 8'd0;
            r_irr_clear <= 8'd0;
            r_data_out  <= 8'd0;
            r_data_oe   <= 1'b0;
            r_lvl       <= 3'd0;
`ifdef AUTO_EOI_EN
            r_lvl_real  <= 1'b0;
`endif
        end else begin
            r_inta_q    <= bus.inta_n;
            r_int_out   <= w_int_out_nxt;
            r_isr       <= w_isr_nxt;
            r_irr_clear <= w_irr_clear_nxt;
            r_data_out  <= w_data_out_nxt;
            r_data_oe   <= w_data_oe_nxt;
            r_lvl       <= w_lvl_nxt;
`ifdef AUTO_EOI_EN
            r_lvl_real  <= w_lvl_real_nxt;
`endif
        end
    end

    assign bus.int_out   = r_int_out;
    assign bus.isr       = r_isr;
    assign bus.irr_clear = r_irr_clear;
    assign bus.data_out  = r_data_out;
    assign bus.data_oe   = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_ack_sequencer
// Description : Directed self-checking bench for interrupt_ack_sequencer.
//               Honours AUTO_EOI_EN for the expected end-of-handshake ISR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_ack_sequencer;

`ifdef AUTO_EOI_EN
    localparam bit C_AUTO = 1'b1;
`else
    localparam bit C_AUTO = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    interrupt_ack_sequencer_if bus_if ();

    interrupt_ack_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full acknowledge of one request starting from IDLE
    task automatic handshake(input logic [7:0] req);
        bus_if.req_onehot = req;
        tick();
        bus_if.inta_n = 1'b0;
        tick();
        bus_if.req_onehot = 8'h00;
        bus_if.inta_n = 1'b1;
        tick();
        bus_if.inta_n = 1'b0;
        tick();
        bus_if.inta_n = 1'b1;
        tick();
    endtask

    task automatic eoi(input logic specific, input logic [2:0] level);
        bus_if.eoi_valid    = 1'b1;
        bus_if.eoi_specific = specific;
        bus_if.eoi_level    = level;
        tick();
        bus_if.eoi_valid    = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus_if.req_onehot   = 8'h00;
        bus_if.vector_base  = 5'h00;
        bus_if.inta_n       = 1'b1;
        bus_if.eoi_valid    = 1'b0;
        bus_if.eoi_specific = 1'b0;
        bus_if.eoi_level    = 3'd0;
        repeat (2) tick();
        chk("rst_int_out", {7'd0, bus_if.int_out}, 8'h00);
        chk("rst_isr", bus_if.isr, 8'h00);
        chk("rst_irr_clear", bus_if.irr_clear, 8'h00);
        chk("rst_data_out", bus_if.data_out, 8'h00);
        chk("rst_data_oe", {7'd0, bus_if.data_oe}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Basic handshake on level 3
        bus_if.vector_base = 5'h10;
        bus_if.req_onehot  = 8'h08;
        tick();
        chk("t1_int_out", {7'd0, bus_if.int_out}, 8'h01);
        chk("t1_isr_pre", bus_if.isr, 8'h00);
        bus_if.inta_n = 1'b0;
        tick();
        chk("t1_isr_set", bus_if.isr, 8'h08);
        chk("t1_irr_pulse", bus_if.irr_clear, 8'h08);
        chk("t1_int_drop", {7'd0, bus_if.int_out}, 8'h00);
        chk("t1_oe_ack1", {7'd0, bus_if.data_oe}, 8'h00);
        bus_if.req_onehot = 8'h00;
        bus_if.inta_n = 1'b1;
        tick();
        chk("t1_irr_end", bus_if.irr_clear, 8'h00);
        chk("t1_oe_gap", {7'd0, bus_if.data_oe}, 8'h00);
        bus_if.inta_n = 1'b0;
        tick();
        chk("t1_vector", bus_if.data_out, 8'h83);
        chk("t1_oe_on", {7'd0, bus_if.data_oe}, 8'h01);
        bus_if.inta_n = 1'b1;
        tick();
        chk("t1_oe_off", {7'd0, bus_if.data_oe}, 8'h00);
        chk("t1_vector_hold", bus_if.data_out, 8'h83);
        chk("t1_isr_end", bus_if.isr, C_AUTO ? 8'h00 : 8'h08);
        eoi(1'b0, 3'd0);
        chk("t1_eoi_clear", bus_if.isr, 8'h00);

`ifndef AUTO_EOI_EN
        // Lower-priority request blocked by an in-service level
        handshake(8'h04);
        chk("t2_isr", bus_if.isr, 8'h04);
        bus_if.req_onehot = 8'h20;
        tick();
        tick();
        chk("t2_blocked", {7'd0, bus_if.int_out}, 8'h00);
        eoi(1'b0, 3'd0);
        chk("t2_eoi_isr", bus_if.isr, 8'h00);
        chk("t2_still_low", {7'd0, bus_if.int_out}, 8'h00);
        tick();
        chk("t2_int_out", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.inta_n = 1'b0;
        tick();
        bus_if.req_onehot = 8'h00;
        bus_if.inta_n = 1'b1;
        tick();
        bus_if.inta_n = 1'b0;
        tick();
        bus_if.inta_n = 1'b1;
        tick();
        chk("t2_isr_lvl5", bus_if.isr, 8'h20);
        eoi(1'b1, 3'd5);
        chk("t2_spec_eoi", bus_if.isr, 8'h00);
`endif

        // Request withdrawn before the first INTA: spurious vector
        bus_if.vector_base = 5'h15;
        bus_if.req_onehot  = 8'h02;
        tick();
        chk("t3_int_out", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.req_onehot = 8'h00;
        tick();
        chk("t3_int_hold", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.inta_n = 1'b0;
        tick();
        chk("t3_isr", bus_if.isr, 8'h00);
        chk("t3_irr", bus_if.irr_clear, 8'h00);
        chk("t3_int_drop", {7'd0, bus_if.int_out}, 8'h00);
        bus_if.inta_n = 1'b1;
        tick();
        bus_if.inta_n = 1'b0;
        tick();
        chk("t3_vector", bus_if.data_out, 8'hAF);
        chk("t3_oe_on", {7'd0, bus_if.data_oe}, 8'h01);
        bus_if.inta_n = 1'b1;
        tick();
        chk("t3_oe_off", {7'd0, bus_if.data_oe}, 8'h00);
        chk("t3_isr_end", bus_if.isr, 8'h00);

`ifndef AUTO_EOI_EN
        // Specific and non-specific EOI on a two-level ISR
        handshake(8'h10);
        handshake(8'h02);
        chk("t4_isr", bus_if.isr, 8'h12);
        eoi(1'b1, 3'd4);
        chk("t4_spec", bus_if.isr, 8'h02);
        eoi(1'b0, 3'd0);
        chk("t4_nonspec", bus_if.isr, 8'h00);
`endif
        eoi(1'b0, 3'd0);
        chk("t4_nonspec_empty", bus_if.isr, 8'h00);

        // Asynchronous reset between the two INTA pulses
        bus_if.vector_base = 5'h10;
        bus_if.req_onehot  = 8'h08;
        tick();
        bus_if.inta_n = 1'b0;
        tick();
        chk("t5_isr_set", bus_if.isr, 8'h08);
        chk("t5_irr_set", bus_if.irr_clear, 8'h08);
        bus_if.req_onehot = 8'h00;
        bus_if.inta_n = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_int_out", {7'd0, bus_if.int_out}, 8'h00);
        chk("t5_isr", bus_if.isr, 8'h00);
        chk("t5_irr", bus_if.irr_clear, 8'h00);
        chk("t5_data_out", bus_if.data_out, 8'h00);
        chk("t5_data_oe", {7'd0, bus_if.data_oe}, 8'h00);
        tick();
        rst_n = 1'b1;
        bus_if.inta_n = 1'b0;
        tick();
        tick();
        chk("t5_no_oe", {7'd0, bus_if.data_oe}, 8'h00);
        chk("t5_no_vector", bus_if.data_out, 8'h00);
        bus_if.inta_n = 1'b1;
        tick();

        // Full handshake again from a clean ISR: auto-EOI decides the final ISR
        bus_if.vector_base = 5'h10;
        handshake(8'h08);
        chk("t6_isr_end", bus_if.isr, C_AUTO ? 8'h00 : 8'h08);
        chk("t6_vector", bus_if.data_out, 8'h83);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
